// File: rtl/pkt_tx_pkg.sv
// Shared types and elaboration-time helpers for the packet transmit sequencer.
package pkt_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    // Words needed to carry pkt_bytes on a data_w-bit bus.
    function automatic int calc_nw(input int pkt_bytes, input int data_w);
        int bpw;
        bpw = data_w / 8;
        return (pkt_bytes + bpw - 1) / bpw;
    endfunction

    // Unused byte lanes in the final word of the packet.
    function automatic int calc_mod(input int pkt_bytes, input int data_w);
        return calc_nw(pkt_bytes, data_w) * (data_w / 8) - pkt_bytes;
    endfunction

    function automatic int mod_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/tx_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle source read latency between
// the source memory and the transmit interface.
module tx_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // NOTE: storage is deliberately not reset; count_q alone says which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: every sequential update uses <= so all registers see the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pkt_tx_sequencer.sv
// Reads fixed-length packets from a source memory and streams them to a MAC
// FIFO interface. Define PKT_TX_STATS_EN to add packet/beat counter outputs.
module pkt_tx_sequencer
    import pkt_tx_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PKT_BYTES = 64,
    parameter int DEPTH     = 256,
    parameter int IPG       = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           tick,
    output logic                           src_rd_en,
    output logic [$clog2(DEPTH)-1:0]       src_addr,
    input  logic [DATA_W-1:0]              src_data,
    output logic [DATA_W-1:0]              ff_tx_data,
    output logic                           ff_tx_sop,
    output logic                           ff_tx_eop,
    output logic [mod_width(DATA_W)-1:0]   ff_tx_mod,
    output logic                           ff_tx_err,
    output logic                           ff_tx_wren,
    input  logic                           ff_tx_rdy,
    output logic                           busy
`ifdef PKT_TX_STATS_EN
    ,
    output logic [31:0]                    pkt_cnt,
    output logic [31:0]                    beat_cnt
`endif
);

    localparam int NW      = calc_nw(PKT_BYTES, DATA_W);
    localparam int MOD_VAL = calc_mod(PKT_BYTES, DATA_W);
    localparam int MOD_W   = mod_width(DATA_W);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int IDX_W   = (NW > 1) ? $clog2(NW) : 1;
    localparam int LEFT_W  = $clog2(NW + 1);
    localparam int GAP_W   = (IPG > 1) ? $clog2(IPG) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEFT_W-1:0]   rd_left_q, rd_left_d;
    logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                inflight_q;

    logic [1:0]          fifo_count;
    logic [DATA_W-1:0]   fifo_head;
    logic [2:0]          occupancy;
    logic                rd_en;
    logic                wren;
    logic                beat;
    logic                is_last;

    tx_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (src_data),
        .pop_i       (beat),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign wren    = (state_q == ST_SEND) && (fifo_count != 2'd0);
    assign beat    = wren && ff_tx_rdy;
    assign is_last = (beat_idx_q == IDX_W'(NW - 1));

    // A word leaving the buffer this cycle frees its slot, which keeps one
    // read issued per cycle while the MAC is ready.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(beat);
    assign rd_en     = (state_q == ST_SEND) && (rd_left_q != '0) && (occupancy < 3'd2);

    // NOTE: every variable gets its default before the case so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_left_d  = rd_left_q;
        beat_idx_d = beat_idx_q;
        gap_d      = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (en && tick) begin
                    state_d    = ST_SEND;
                    rd_left_d  = LEFT_W'(NW);
                    beat_idx_d = '0;
                end
            end
            ST_SEND: begin
                if (rd_en) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - LEFT_W'(1);
                end
                if (beat) begin
                    if (is_last) begin
                        beat_idx_d = '0;
                        if (IPG == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_W'(IPG - 1);
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_left_q  <= '0;
            beat_idx_q <= '0;
            gap_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_left_q  <= rd_left_d;
            beat_idx_q <= beat_idx_d;
            gap_q      <= gap_d;
            inflight_q <= rd_en;
        end
    end

    assign src_rd_en  = rd_en;
    assign src_addr   = addr_q;
    assign ff_tx_wren = wren;
    assign ff_tx_data = wren ? fifo_head : '0;
    assign ff_tx_sop  = wren && (beat_idx_q == '0);
    assign ff_tx_eop  = wren && is_last;
    assign ff_tx_mod  = (wren && is_last) ? MOD_W'(MOD_VAL) : '0;
    assign ff_tx_err  = 1'b0;
    assign busy       = (state_q != ST_IDLE);

`ifdef PKT_TX_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (beat) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (beat && is_last) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: doc/pkt_tx_sequencer.md
PKT_TX_SEQUENCER -- requirements
Module: pkt_tx_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, transmit word width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter PKT_BYTES, default 64, packet length in bytes (>= 1).
REQ-003 SHALL have parameter DEPTH, default 256, source memory depth in words (power of 2).
REQ-004 SHALL have parameter IPG, default 12, idle cycles enforced after each packet (>= 0).
REQ-005 SHALL have ports, in this order:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous active-high reset.
  en  in  1  enables packet starts.
  tick  in  1  one-cycle pacing pulse (from clock divider).
  src_rd_en  out  1  source memory read strobe.
  src_addr  out  $clog2(DEPTH)  source word address.
  src_data  in  DATA_W  read data, valid the cycle after src_rd_en.
  ff_tx_data  out  DATA_W  transmit word.
  ff_tx_sop / ff_tx_eop  out  1  first / last word of packet.
  ff_tx_mod  out  max(1,$clog2(DATA_W/8))  empty bytes in eop word.
  ff_tx_err  out  1  packet error flag.
  ff_tx_wren  out  1  word valid.
  ff_tx_rdy  in  1  MAC ready.
  busy  out  1  high in any state other than IDLE.
REQ-006 One clock; reset is synchronous and active-high; ports named clk and rst.

Function
REQ-010 SHALL implement states IDLE, SEND, GAP.
REQ-011 IDLE->SEND when en=1 and tick=1 in the same cycle; tick outside IDLE SHALL be ignored, not queued.
REQ-012 Words per packet SHALL be NW=ceil(PKT_BYTES/(DATA_W/8)); ff_tx_mod SHALL equal NW*(DATA_W/8)-PKT_BYTES on the eop word and 0 otherwise.
REQ-013 A beat SHALL transfer only in a cycle with ff_tx_wren=1 and ff_tx_rdy=1; while ff_tx_wren=1 and ff_tx_rdy=0, data/sop/eop/mod SHALL hold stable.
REQ-014 ff_tx_sop SHALL be high only on word 0, ff_tx_eop only on word NW-1; both high together when NW=1.
REQ-015 Reads SHALL feed a 2-entry buffer; src_rd_en SHALL assert only when (buffered + in-flight) < 2 and unread words remain in the packet; src_addr SHALL increment after each read, wrapping DEPTH-1->0, and SHALL persist across packets.
REQ-016 With tick at cycle T in IDLE and ff_tx_rdy held 1: src_rd_en at T+1, first ff_tx_wren (sop) at T+3, then one beat per cycle (no bubbles).
REQ-017 After eop transfers: go to GAP for exactly IPG cycles, then IDLE; if IPG=0, go directly to IDLE.
REQ-018 en deasserted mid-packet SHALL NOT truncate the packet; it only blocks the next start.
REQ-019 ff_tx_err SHALL be 0 always (reserved).

Reset
REQ-030 rst SHALL set state IDLE, src_addr=0, buffer empty, in-flight cleared, and all outputs 0, at the next clk edge.
REQ-031 rst mid-packet SHALL abort without emitting eop; the next packet starts at src_addr=0 with sop.

Configuration
REQ-040 Macro PKT_TX_STATS_EN: when defined, SHALL add outputs pkt_cnt (32) and beat_cnt (32), counting transferred eop beats and transferred beats, reset to 0, wrapping at 2^32; when undefined, these ports and counters SHALL not exist.

Structure
REQ-050 Package pkt_tx_pkg SHALL hold the state enum typedef and the NW/mod computation function.
REQ-051 The 2-entry buffer SHALL be sub-module tx_skid_fifo (parameter DATA_W; push, pop, count, head data).

Verification
REQ-060 Defaults, rdy=1, en=1, one tick -> 16 beats, sop on beat 0, eop on beat 15, mod=0, src_addr reads 0..15, busy low 12 cycles after eop.
REQ-061 PKT_BYTES=61, DATA_W=32 -> NW=16, mod=3 on eop beat only.
REQ-062 rdy toggling 1,0,0,1 pattern -> every word delivered once in order, outputs stable during stalls, no overflow of tx_skid_fifo.
REQ-063 DEPTH=16, 3 packets -> src_addr wraps 15->0 during packet 1; data sequence continuous.
REQ-064 tick during SEND/GAP and en=0 mid-packet -> no extra packet, current packet completes.
REQ-065 rst at beat 7 -> all outputs 0 next cycle, next packet starts sop from address 0; with PKT_TX_STATS_EN, pkt_cnt=0.
